// File: rtl/fp_ctrl_pkg.sv
// Shared constants and helpers for the floating-point adder arbiter.
// Covers opcodes, FSM state encoding, the stall guard and operand decoding.
package fp_ctrl_pkg;

  localparam logic [1:0] OP_FAD   = 2'b00;
  localparam logic [1:0] OP_FSB   = 2'b01;
  localparam logic [1:0] OP_FLT   = 2'b10;
  localparam logic [1:0] OP_FLOOR = 2'b11;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int RUN_TIMEOUT = 8;

  typedef struct packed {
    logic        u;
    logic        v;
    logic [31:0] x;
    logic [31:0] y;
  } fa_cmd_t;

  // Subtract is an add with the y sign bit flipped; FLT/FLOOR only steer u/v.
  function automatic fa_cmd_t decode_cmd(input logic [1:0] op,
                                         input logic [31:0] x,
                                         input logic [31:0] y);
    fa_cmd_t c;
    c.u = 1'b0;
    c.v = 1'b0;
    c.x = x;
    c.y = y;
    case (op)
      OP_FAD:   c.y = y;
      OP_FSB:   c.y = {~y[31], y[30:0]};
      OP_FLT:   c.u = 1'b1;
      OP_FLOOR: c.v = 1'b1;
      default:  c.y = y;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from last+1 with wrap.
// Produces a one-hot grant and the matching index.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx
);

  always_comb begin
    int   idx;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = (int'(last) + off) % NREQ;
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = idx[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/fp_adder_arbiter.sv
// Shares one pipelined FP adder between NREQ requesters with round-robin grants.
// Holds operands for the whole adder pass and returns the result with a one-cycle ack.
module fp_adder_arbiter
  import fp_ctrl_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    op,
  input  logic [32*NREQ-1:0]   xa,
  input  logic [32*NREQ-1:0]   ya,
  output logic [NREQ-1:0]      ack,
  output logic [31:0]          res,
  output logic                 busy,
  output logic                 fa_run,
  output logic                 fa_u,
  output logic                 fa_v,
  output logic [31:0]          fa_x,
  output logic [31:0]          fa_y,
  input  logic                 fa_stall,
  input  logic [31:0]          fa_z
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [1:0]      state;
  logic [IW-1:0]   last;
  logic [NREQ-1:0] g_hot;
  logic [3:0]      run_cnt;
  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;
  fa_cmd_t         cmd;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req     (req),
    .last    (last),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign cmd  = decode_cmd(op[2*gnt_idx +: 2], xa[32*gnt_idx +: 32], ya[32*gnt_idx +: 32]);
  assign busy = (state != IDLE);

  // Operands are latched only on the grant edge, so later requester changes are ignored.
  // Dropping fa_run in DONE lets the adder's internal pass counter clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      last    <= IW'(NREQ - 1);
      g_hot   <= '0;
      run_cnt <= '0;
      ack     <= '0;
      res     <= '0;
      fa_run  <= 1'b0;
      fa_u    <= 1'b0;
      fa_v    <= 1'b0;
      fa_x    <= '0;
      fa_y    <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack <= '0;
          if (|req) begin
            fa_u    <= cmd.u;
            fa_v    <= cmd.v;
            fa_x    <= cmd.x;
            fa_y    <= cmd.y;
            fa_run  <= 1'b1;
            last    <= gnt_idx;
            g_hot   <= gnt;
            run_cnt <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          if (!fa_stall) begin
            res    <= fa_z;
            fa_run <= 1'b0;
            ack    <= g_hot;
            state  <= DONE;
          end else if (run_cnt == 4'(RUN_TIMEOUT - 1)) begin
            // A stuck adder still acks with a zero result so nobody locks up.
            res    <= '0;
            fa_run <= 1'b0;
            ack    <= g_hot;
            state  <= DONE;
          end else begin
            run_cnt <= run_cnt + 4'd1;
          end
        end
        DONE: begin
          ack   <= '0;
          state <= IDLE;
        end
        default: begin
          ack    <= '0;
          fa_run <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
